// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// instruction_decode : IF/ID + register file + ID/EX decode stage with
// load-use / branch hazard detection and jump redirect back to fetch.
// Revision: 1.0
// ============================================================================
module instruction_decode #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 4,
  parameter int REG_N  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruction,
  input  logic [PC_W-1:0]   Pc_4,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              mux_ctrl,
  output logic [PC_W-1:0]   jp_address,
  output logic              stall_fetch,
  output logic              ex_valid,
  output logic [5:0]        ex_opcode,
  output logic [5:0]        ex_funct,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read
);

  localparam logic [5:0] C_OP_RTYPE = 6'h00;
  localparam logic [5:0] C_OP_J     = 6'h02;
  localparam logic [5:0] C_OP_JAL   = 6'h03;
  localparam logic [5:0] C_OP_BEQ   = 6'h04;
  localparam logic [5:0] C_OP_BNE   = 6'h05;
  localparam logic [5:0] C_OP_ANDI  = 6'h0C;
  localparam logic [5:0] C_OP_ORI   = 6'h0D;
  localparam logic [5:0] C_OP_XORI  = 6'h0E;
  localparam logic [5:0] C_OP_LUI   = 6'h0F;
  localparam logic [5:0] C_OP_LW    = 6'h23;

  // IF/ID pipeline register
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]   if_pc4_q,   if_pc4_d;
  logic              redirect_done_q, redirect_done_d;

  // ID/EX pipeline register
  logic              ex_valid_q,     ex_valid_d;
  logic [5:0]        ex_opcode_q,    ex_opcode_d;
  logic [5:0]        ex_funct_q,     ex_funct_d;
  logic [DATA_W-1:0] ex_rs_data_q,   ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q,   ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,       ex_imm_d;
  logic [4:0]        ex_dest_q,      ex_dest_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q,  ex_mem_read_d;

  logic [DATA_W-1:0] rf_q [REG_N];

  // Decoded fields of the instruction held in IF/ID
  logic [5:0]        id_opcode;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic [DATA_W-1:0] dec_imm;
  logic [4:0]        dec_dest;
  logic              dec_reg_write;
  logic              is_branch;
  logic              ex_dest_match;
  logic              hazard;
  logic              hold;
  logic              take;

  assign id_opcode = if_instr_q[31:26];
  assign id_rs     = if_instr_q[25:21];
  assign id_rt     = if_instr_q[20:16];
  assign id_rd     = if_instr_q[15:11];

  // Write-first bypass so an instruction reading the register being written
  // back this cycle sees the new value.
  assign rs_data = (id_rs == 5'd0) ? '0 :
                   (wb_en && (wb_addr == id_rs)) ? wb_data : rf_q[id_rs];
  assign rt_data = (id_rt == 5'd0) ? '0 :
                   (wb_en && (wb_addr == id_rt)) ? wb_data : rf_q[id_rt];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Hazard detection
  assign is_branch     = (id_opcode == C_OP_BEQ) || (id_opcode == C_OP_BNE);
  assign ex_dest_match = (ex_dest_q != 5'd0) &&
                         ((ex_dest_q == id_rs) || (ex_dest_q == id_rt));
  assign hazard        = if_valid_q && ex_valid_q && ex_reg_write_q &&
                         ex_dest_match && (ex_mem_read_q || is_branch);
  assign hold          = stall_in || hazard;
  assign stall_fetch   = reset && hold;

  // Redirect: redirect_done suppresses a second pulse while a taken jump sits
  // frozen in IF/ID.
  always_comb begin
    take       = 1'b0;
    jp_address = '0;
    if (if_valid_q && !flush && !redirect_done_q && !hazard) begin
      unique case (id_opcode)
        C_OP_J, C_OP_JAL: begin
          take       = 1'b1;
          jp_address = if_instr_q[PC_W-1:0];
        end
        C_OP_BEQ: begin
          take       = (rs_data == rt_data);
          jp_address = take ? (if_pc4_q + if_instr_q[PC_W-1:0]) : '0;
        end
        C_OP_BNE: begin
          take       = (rs_data != rt_data);
          jp_address = take ? (if_pc4_q + if_instr_q[PC_W-1:0]) : '0;
        end
        default: begin
          take       = 1'b0;
          jp_address = '0;
        end
      endcase
    end
  end

  assign mux_ctrl = take;

  // IF/ID next state
  always_comb begin
    if_valid_d      = if_valid_q;
    if_instr_d      = if_instr_q;
    if_pc4_d        = if_pc4_q;
    redirect_done_d = redirect_done_q;
    if (flush) begin
      if_valid_d      = 1'b0;
      redirect_done_d = 1'b0;
    end else if (hold) begin
      if (take && stall_in) redirect_done_d = 1'b1;
    end else begin
      if_valid_d      = 1'b1;
      if_instr_d      = instruction;
      if_pc4_d        = Pc_4;
      redirect_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_valid_q      <= 1'b0;
      if_instr_q      <= '0;
      if_pc4_q        <= '0;
      redirect_done_q <= 1'b0;
    end else begin
      if_valid_q      <= if_valid_d;
      if_instr_q      <= if_instr_d;
      if_pc4_q        <= if_pc4_d;
      redirect_done_q <= redirect_done_d;
    end
  end

  // Field decode
  always_comb begin
    dec_imm       = {{(DATA_W-16){if_instr_q[15]}}, if_instr_q[15:0]};
    dec_dest      = id_rt;
    dec_reg_write = 1'b0;
    unique case (id_opcode)
      C_OP_ANDI, C_OP_ORI, C_OP_XORI:
        dec_imm = {{(DATA_W-16){1'b0}}, if_instr_q[15:0]};
      C_OP_LUI:
        dec_imm = {if_instr_q[15:0], {(DATA_W-16){1'b0}}};
      C_OP_JAL:
        dec_imm = {{(DATA_W-PC_W){1'b0}}, if_pc4_q};
      default: ;
    endcase
    if (id_opcode == C_OP_RTYPE)    dec_dest = id_rd;
    else if (id_opcode == C_OP_JAL) dec_dest = 5'd31;
    if ((id_opcode == C_OP_RTYPE) || (id_opcode == C_OP_JAL) ||
        (id_opcode == C_OP_LW) ||
        ((id_opcode >= 6'h08) && (id_opcode <= 6'h0F)))
      dec_reg_write = 1'b1;
  end

  // ID/EX next state
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_opcode_d    = ex_opcode_q;
    ex_funct_d     = ex_funct_q;
    ex_rs_data_d   = ex_rs_data_q;
    ex_rt_data_d   = ex_rt_data_q;
    ex_imm_d       = ex_imm_q;
    ex_dest_d      = ex_dest_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    if (flush || (!stall_in && (hazard || !if_valid_q))) begin
      ex_valid_d     = 1'b0;
      ex_opcode_d    = '0;
      ex_funct_d     = '0;
      ex_rs_data_d   = '0;
      ex_rt_data_d   = '0;
      ex_imm_d       = '0;
      ex_dest_d      = '0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
    end else if (!stall_in) begin
      ex_valid_d     = 1'b1;
      ex_opcode_d    = id_opcode;
      ex_funct_d     = if_instr_q[5:0];
      ex_rs_data_d   = rs_data;
      ex_rt_data_d   = rt_data;
      ex_imm_d       = dec_imm;
      ex_dest_d      = dec_dest;
      ex_reg_write_d = dec_reg_write;
      ex_mem_read_d  = (id_opcode == C_OP_LW);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q     <= 1'b0;
      ex_opcode_q    <= '0;
      ex_funct_q     <= '0;
      ex_rs_data_q   <= '0;
      ex_rt_data_q   <= '0;
      ex_imm_q       <= '0;
      ex_dest_q      <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_opcode_q    <= ex_opcode_d;
      ex_funct_q     <= ex_funct_d;
      ex_rs_data_q   <= ex_rs_data_d;
      ex_rt_data_q   <= ex_rt_data_d;
      ex_imm_q       <= ex_imm_d;
      ex_dest_q      <= ex_dest_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_opcode    = ex_opcode_q;
  assign ex_funct     = ex_funct_q;
  assign ex_rs_data   = ex_rs_data_q;
  assign ex_rt_data   = ex_rt_data_q;
  assign ex_imm       = ex_imm_q;
  assign ex_dest      = ex_dest_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
// tb_instruction_decode : directed self-checking bench for instruction_decode.
// Revision: 1.0
// ============================================================================
module tb_instruction_decode;

  localparam int DATA_W = 32;
  localparam int PC_W   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] instruction;
  logic [PC_W-1:0]   Pc_4;
  logic              stall_in, flush, wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              mux_ctrl, stall_fetch, ex_valid, ex_reg_write, ex_mem_read;
  logic [PC_W-1:0]   jp_address;
  logic [5:0]        ex_opcode, ex_funct;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]        ex_dest;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] JMP = 32'h0800_000A;

  instruction_decode #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_N(32)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .Pc_4(Pc_4),
    .stall_in(stall_in), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .mux_ctrl(mux_ctrl), .jp_address(jp_address),
    .stall_fetch(stall_fetch), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_funct(ex_funct), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [PC_W-1:0] pc4);
    instruction = ins;
    Pc_4        = pc4;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall_in = 1'b0; flush = 1'b0; wb_en = 1'b0;
    wb_addr = '0; wb_data = '0; drive(NOP, '0);
    tick(); tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got %b want 0", ex_valid); end
    n_checks++; if (mux_ctrl !== 1'b0) begin n_fail++; $display("FAIL reset_mux_ctrl got %b want 0", mux_ctrl); end
    n_checks++; if (stall_fetch !== 1'b0) begin n_fail++; $display("FAIL reset_stall_fetch got %b want 0", stall_fetch); end
    n_checks++; if (ex_imm !== 32'h0) begin n_fail++; $display("FAIL reset_ex_imm got %h want 0", ex_imm); end
    reset = 1'b1;
    tick(); tick();
  endtask

  task automatic test_decode();
    drive(32'h2001_0005, 4'h1); tick();
    drive(32'h3402_FFFF, 4'h2); tick();
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b want 1", ex_valid); end
    n_checks++; if (ex_opcode !== 6'h08) begin n_fail++; $display("FAIL addi_opcode got %h want 08", ex_opcode); end
    n_checks++; if (ex_dest !== 5'd1) begin n_fail++; $display("FAIL addi_dest got %0d want 1", ex_dest); end
    n_checks++; if (ex_imm !== 32'h5) begin n_fail++; $display("FAIL addi_imm got %h want 5", ex_imm); end
    n_checks++; if (ex_reg_write !== 1'b1) begin n_fail++; $display("FAIL addi_regwrite got %b want 1", ex_reg_write); end
    n_checks++; if (ex_mem_read !== 1'b0) begin n_fail++; $display("FAIL addi_memread got %b want 0", ex_mem_read); end
    drive(32'h3C03_ABCD, 4'h3); tick();
    n_checks++; if (ex_imm !== 32'h0000_FFFF) begin n_fail++; $display("FAIL ori_zext got %h want 0000ffff", ex_imm); end
    n_checks++; if (ex_dest !== 5'd2) begin n_fail++; $display("FAIL ori_dest got %0d want 2", ex_dest); end
    drive(32'h2001_FFFF, 4'h4); tick();
    n_checks++; if (ex_imm !== 32'hABCD_0000) begin n_fail++; $display("FAIL lui_imm got %h want abcd0000", ex_imm); end
    drive(32'h0C00_0005, 4'h7); tick();
    n_checks++; if (ex_imm !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL addi_sext got %h want ffffffff", ex_imm); end
    drive(NOP, 4'h8); tick();
    n_checks++; if (ex_dest !== 5'd31) begin n_fail++; $display("FAIL jal_dest got %0d want 31", ex_dest); end
    n_checks++; if (ex_imm !== 32'h7) begin n_fail++; $display("FAIL jal_link got %h want 7", ex_imm); end
    n_checks++; if (ex_reg_write !== 1'b1) begin n_fail++; $display("FAIL jal_regwrite got %b want 1", ex_reg_write); end
    tick(); tick();
  endtask

  task automatic test_load_use();
    drive(32'h8C22_0000, 4'h1); tick();
    drive(32'h0042_1820, 4'h2); tick();
    n_checks++; if (ex_mem_read !== 1'b1) begin n_fail++; $display("FAIL lw_memread got %b want 1", ex_mem_read); end
    n_checks++; if (stall_fetch !== 1'b1) begin n_fail++; $display("FAIL loaduse_stall got %b want 1", stall_fetch); end
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL loaduse_bubble got %b want 0", ex_valid); end
    n_checks++; if (stall_fetch !== 1'b0) begin n_fail++; $display("FAIL loaduse_stall_len got %b want 0", stall_fetch); end
    drive(NOP, 4'h3);
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'hDEAD_BEEF;
    tick();
    wb_en = 1'b0;
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL add_issue got %b want 1", ex_valid); end
    n_checks++; if (ex_rs_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL add_rs_bypass got %h want deadbeef", ex_rs_data); end
    n_checks++; if (ex_rt_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL add_rt_bypass got %h want deadbeef", ex_rt_data); end
    n_checks++; if (ex_funct !== 6'h20) begin n_fail++; $display("FAIL add_funct got %h want 20", ex_funct); end
    n_checks++; if (ex_dest !== 5'd3) begin n_fail++; $display("FAIL add_dest got %0d want 3", ex_dest); end
    tick(); tick();
  endtask

  task automatic test_jump();
    int pulses;
    drive(JMP, 4'h1); tick();
    n_checks++; if (mux_ctrl !== 1'b1) begin n_fail++; $display("FAIL j_mux got %b want 1", mux_ctrl); end
    n_checks++; if (jp_address !== 4'hA) begin n_fail++; $display("FAIL j_addr got %h want a", jp_address); end
    drive(NOP, 4'h2); tick();
    n_checks++; if (mux_ctrl !== 1'b0) begin n_fail++; $display("FAIL j_one_cycle got %b want 0", mux_ctrl); end
    drive(JMP, 4'h3); tick();
    stall_in = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (mux_ctrl === 1'b1) pulses++;
      n_checks++; if (stall_fetch !== 1'b1) begin n_fail++; $display("FAIL j_stall_fetch cycle %0d got %b want 1", i, stall_fetch); end
      tick();
    end
    stall_in = 1'b0;
    #1;
    if (mux_ctrl === 1'b1) pulses++;
    drive(NOP, 4'h4); tick();
    if (mux_ctrl === 1'b1) pulses++;
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL j_single_pulse got %0d pulses want 1", pulses); end
    tick(); tick();
  endtask

  task automatic test_branch();
    drive(32'h2001_0005, 4'h1); tick();
    drive(32'h1021_0003, 4'hE); tick();
    n_checks++; if (stall_fetch !== 1'b1) begin n_fail++; $display("FAIL br_hazard_stall got %b want 1", stall_fetch); end
    n_checks++; if (mux_ctrl !== 1'b0) begin n_fail++; $display("FAIL br_hazard_mux got %b want 0", mux_ctrl); end
    tick();
    n_checks++; if (mux_ctrl !== 1'b1) begin n_fail++; $display("FAIL beq_taken got %b want 1", mux_ctrl); end
    n_checks++; if (jp_address !== 4'h1) begin n_fail++; $display("FAIL beq_wrap_addr got %h want 1", jp_address); end
    drive(32'h1421_0003, 4'hF); tick();
    n_checks++; if (ex_reg_write !== 1'b0) begin n_fail++; $display("FAIL beq_regwrite got %b want 0", ex_reg_write); end
    n_checks++; if (mux_ctrl !== 1'b0) begin n_fail++; $display("FAIL bne_equal_mux got %b want 0", mux_ctrl); end
    n_checks++; if (jp_address !== 4'h0) begin n_fail++; $display("FAIL bne_equal_addr got %h want 0", jp_address); end
    drive(32'h1422_0002, 4'h3); tick();
    n_checks++; if (mux_ctrl !== 1'b1) begin n_fail++; $display("FAIL bne_taken got %b want 1", mux_ctrl); end
    n_checks++; if (jp_address !== 4'h5) begin n_fail++; $display("FAIL bne_addr got %h want 5", jp_address); end
    drive(NOP, 4'h4); tick(); tick();
  endtask

  task automatic test_flush_stall();
    drive(JMP, 4'h1); tick();
    flush = 1'b1; stall_in = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_1234;
    #1;
    n_checks++; if (mux_ctrl !== 1'b0) begin n_fail++; $display("FAIL flush_mask_mux got %b want 0", mux_ctrl); end
    tick();
    flush = 1'b0; stall_in = 1'b0;
    wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ex_valid got %b want 0", ex_valid); end
    n_checks++; if (mux_ctrl !== 1'b0) begin n_fail++; $display("FAIL flush_if_valid got %b want 0", mux_ctrl); end
    drive(32'h00E0_4020, 4'h2); tick();
    drive(NOP, 4'h3); tick();
    wb_en = 1'b0;
    n_checks++; if (ex_rs_data !== 32'h0000_1234) begin n_fail++; $display("FAIL r7_write got %h want 00001234", ex_rs_data); end
    n_checks++; if (ex_rt_data !== 32'h0) begin n_fail++; $display("FAIL r0_zero got %h want 0", ex_rt_data); end
    n_checks++; if (ex_dest !== 5'd8) begin n_fail++; $display("FAIL flush_add_dest got %0d want 8", ex_dest); end
    tick(); tick();
  endtask

  task automatic test_reset_midstream();
    drive(32'h2001_0005, 4'h1); tick();
    drive(JMP, 4'h2); tick();
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got %b want 1", ex_valid); end
    reset = 1'b0;
    #1;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid got %b want 0", ex_valid); end
    n_checks++; if (mux_ctrl !== 1'b0) begin n_fail++; $display("FAIL async_reset_mux got %b want 0", mux_ctrl); end
    n_checks++; if (jp_address !== 4'h0) begin n_fail++; $display("FAIL async_reset_addr got %h want 0", jp_address); end
    n_checks++; if (ex_imm !== 32'h0) begin n_fail++; $display("FAIL async_reset_imm got %h want 0", ex_imm); end
    n_checks++; if (ex_dest !== 5'd0) begin n_fail++; $display("FAIL async_reset_dest got %0d want 0", ex_dest); end
    n_checks++; if (ex_reg_write !== 1'b0) begin n_fail++; $display("FAIL async_reset_regwrite got %b want 0", ex_reg_write); end
    #1;
    reset = 1'b1;
    drive(32'h00E2_4020, 4'h3); tick();
    drive(NOP, 4'h4); tick();
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL post_reset_valid got %b want 1", ex_valid); end
    n_checks++; if (ex_rs_data !== 32'h0) begin n_fail++; $display("FAIL post_reset_r7 got %h want 0", ex_rs_data); end
    n_checks++; if (ex_rt_data !== 32'h0) begin n_fail++; $display("FAIL post_reset_r2 got %h want 0", ex_rt_data); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_jump();
    test_branch();
    test_flush_stall();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
